// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver with single-entry valid/ready output register
module uart_rx_byte #(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic             rx_meta;
    logic             rx_s;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_nxt;
    logic [7:0]       shift;
    logic [7:0]       shift_nxt;
    logic             complete;
    logic             stop_bad;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM state, bit timer, bit index and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
        end
    end

    // Next-state logic: START waits half a bit to land mid-bit, then every sample is a full bit apart
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        complete    = 1'b0;
        stop_bad    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                if (cnt == CNT_HALF_LAST) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt   = DATA;
                        bit_idx_nxt = 3'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_nxt            = '0;
                    shift_nxt[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (rx_s) begin
                        complete = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output register: a full register only accepts a new byte when it is drained in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= complete && out_valid && !out_ready;
            if (complete) begin
                if (!out_valid || out_ready) begin
                    out_data  <= shift;
                    out_valid <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - directed self-checking bench for uart_rx_byte
module tb_uart_rx_byte;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_q[$];
    int         fe_cycles   = 0;
    int         ov_cycles   = 0;
    int         both_cycles = 0;

    uart_rx_byte #(
        .CLK_FREQ_HZ (100_000_000),
        .BAUD        (115200),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Record handshakes and error pulses away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (frame_err) fe_cycles++;
            if (overrun) ov_cycles++;
            if (frame_err && overrun) both_cycles++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        fe_cycles   = 0;
        ov_cycles   = 0;
        both_cycles = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] str [12];
        int lat;
        int bc;
        int vs;
        str = '{8'h54, 8'h65, 8'h73, 8'h74, 8'h20, 8'h65,
                8'h63, 8'h68, 8'h6F, 8'h20, 8'h20, 8'h20};

        // Reset held with rx toggling
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rx = ~rx;
            @(negedge clk);
            check("reset_outputs", {out_valid, frame_err, overrun, busy, out_data}, 32'h0);
        end
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bc  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) bc++;
        end
        check("idle_busy", bc, 0);

        // Single byte, consumer not ready
        clear_mon();
        out_ready = 1'b0;
        lat = 0;
        fork
            send_frame(8'h54, 1'b1);
            begin
                while (!out_valid && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("single_valid", out_valid, 1);
        check("single_latency_in_range", (lat >= 2 + HALF + 9 * CPB - 1) && (lat <= 2 + HALF + 9 * CPB + 1), 1);
        check("single_data", out_data, 8'h54);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("single_drained", out_valid, 0);
        idle(CPB);

        // Back-to-back string, consumer always ready
        clear_mon();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) send_frame(str[i], 1'b1);
        idle(2 * CPB);
        check("string_count", got_q.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < got_q.size()) check($sformatf("string_byte%0d", i), got_q[i], str[i]);
        end
        check("string_frame_err", fe_cycles, 0);
        check("string_overrun", ov_cycles, 0);

        // Glitch shorter than half a bit
        clear_mon();
        bc = 0;
        vs = 0;
        rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 3) rx = 1'b1;
            if (busy) bc++;
            if (out_valid) vs++;
        end
        check("glitch_busy_pulsed", (bc >= HALF - 2) && (bc <= HALF + 2), 1);
        check("glitch_busy_end", busy, 0);
        check("glitch_no_valid", vs, 0);
        check("glitch_no_frame_err", fe_cycles, 0);

        // Framing error then a good byte
        clear_mon();
        send_frame(8'hA5, 1'b0);
        idle(2 * CPB);
        check("frame_err_cycles", fe_cycles, 1);
        check("frame_err_no_valid", out_valid, 0);
        check("frame_err_no_byte", got_q.size(), 0);
        check("frame_err_no_overrun", ov_cycles, 0);
        send_frame(8'h3C, 1'b1);
        idle(2 * CPB);
        check("after_ferr_count", got_q.size(), 1);
        if (got_q.size() > 0) check("after_ferr_data", got_q[0], 8'h3C);

        // Overrun: second byte arrives while the first is still held
        clear_mon();
        out_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(2 * CPB);
        check("overrun_valid", out_valid, 1);
        check("overrun_data_held", out_data, 8'h11);
        check("overrun_cycles", ov_cycles, 1);
        check("overrun_no_frame_err", fe_cycles, 0);
        check("overrun_not_with_ferr", both_cycles, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("overrun_drained", out_valid, 0);

        // Reset during bit 4 of 0x33 aborts the frame
        clear_mon();
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(8'h33 >> i);
            repeat (CPB) @(negedge clk);
        end
        rx = 1'(8'h33 >> 4);
        repeat (HALF) @(negedge clk);
        check("mid_frame_busy", busy, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        check("mid_reset_outputs", {out_valid, frame_err, overrun, busy, out_data}, 32'h0);
        rst = 1'b0;
        idle(3 * CPB);
        check("aborted_no_byte", got_q.size(), 0);
        check("aborted_no_valid", out_valid, 0);
        check("aborted_no_errs", fe_cycles + ov_cycles, 0);
        send_frame(8'h44, 1'b1);
        idle(2 * CPB);
        check("after_reset_count", got_q.size(), 1);
        if (got_q.size() > 0) check("after_reset_data", got_q[0], 8'h44);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
